// File: rtl/fetch_pkg.sv
// Shared types and helpers for the prefetching fetch stage.
// Holds the FIFO entry layout, the NOP filler and the counter-width helper.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Bits needed for a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Request/response bus between the fetch stage and the instruction cache.
// Master is the fetch side, slave is the icache side.
interface fetch_prefetch_if;

    logic        icache_req_valid_o;
    logic        icache_req_ready_i;
    logic [31:0] icache_addr_o;
    logic        icache_rvalid_i;
    logic [31:0] icache_rdata_i;

    modport master (
        output icache_req_valid_o,
        output icache_addr_o,
        input  icache_req_ready_i,
        input  icache_rvalid_i,
        input  icache_rdata_i
    );

    modport slave (
        input  icache_req_valid_o,
        input  icache_addr_o,
        output icache_req_ready_i,
        output icache_rvalid_i,
        output icache_rdata_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO with synchronous clear, used for both the prefetch
// buffer and the per-request PC queue.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    parameter int  CW      = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Explicit wrap keeps non-power-of-two depths (the PC queue) correct.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage with several icache requests in flight and a prefetch FIFO
// towards decode; flushes redirect the PC and swallow stale responses.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic [31:0]             flush_pc_i,
    input  logic                    ready_in,
    output logic                    valid_out,
    output logic [31:0]             pc_out,
    output logic [31:0]             instr_out,
    fetch_prefetch_if.master        icache
);

    localparam int IW = cnt_width(MAX_OUTSTANDING);
    localparam int CW = cnt_width(DEPTH);

    logic [31:0]   fetch_pc;
    logic [IW-1:0] inflight;
    logic [IW-1:0] drop;
    logic [31:0]   reserved;
    logic          req_fire;
    logic          resp;
    logic          resp_keep;
    logic          deq;

    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_wdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    logic [31:0]   pcq_head;
    logic [IW-1:0] pcq_count;
    logic          pcq_full;
    logic          pcq_empty;

    // Live requests plus buffered entries must never exceed the FIFO, so every
    // kept response is guaranteed a slot; dropped ones reserve nothing.
    assign reserved = 32'(inflight) - 32'(drop) + 32'(fifo_count);

    assign icache.icache_req_valid_o = rst_n && !flush_i
                                       && (32'(inflight) < 32'(MAX_OUTSTANDING))
                                       && (reserved < 32'(DEPTH));
    assign icache.icache_addr_o      = fetch_pc;

    assign req_fire   = icache.icache_req_valid_o && icache.icache_req_ready_i;
    assign resp       = icache.icache_rvalid_i && (inflight != '0);
    assign resp_keep  = resp && !flush_i && (drop == '0);
    assign deq        = !fifo_empty && ready_in && !flush_i;
    assign fifo_wdata = '{pc: pcq_head, instr: icache.icache_rdata_i};

    assign valid_out = !fifo_empty;
    assign pc_out    = fifo_empty ? 32'h0 : fifo_head.pc;
    assign instr_out = fifo_empty ? NOP_INSTR : fifo_head.instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (flush_i) begin
            fetch_pc <= flush_pc_i;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (req_fire && !resp) begin
            inflight <= inflight + IW'(1);
        end else if (resp && !req_fire) begin
            inflight <= inflight - IW'(1);
        end
    end

    // Everything still owed at a flush belongs to the old path, except a
    // response that lands in the flush cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop <= '0;
        end else if (flush_i) begin
            drop <= inflight - IW'(resp);
        end else if (resp && (drop != '0)) begin
            drop <= drop - IW'(1);
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_prefetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush_i),
        .push      (resp_keep),
        .push_data (fifo_wdata),
        .pop       (deq),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    fetch_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .entry_t (logic [31:0])
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (resp),
        .head      (pcq_head),
        .count     (pcq_count),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    a_no_orphan_response: assert property (@(posedge clk) disable iff (!rst_n)
        icache.icache_rvalid_i |-> (inflight != '0));
    a_prefetch_has_room: assert property (@(posedge clk) disable iff (!rst_n)
        resp_keep |-> (!fifo_full || deq));
    a_pcq_tracks_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        pcq_count == inflight);
    a_pcq_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        resp |-> !pcq_empty);
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        req_fire |-> (!pcq_full || resp));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: streaming, back-pressure, flushes with
// responses in flight, async reset mid-burst and PC wrap-around.
module tb_fetch_prefetch;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        flush_i    = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic        ready_in   = 1'b0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    int cyc      = 0;
    logic [31:0] next_pc;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t pend[$];

    fetch_prefetch_if ic();

    fetch_prefetch #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .flush_pc_i (flush_pc_i),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .pc_out     (pc_out),
        .instr_out  (instr_out),
        .icache     (ic)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ic_data(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // In-order icache model: answers each accepted request `lat` cycles later.
    always @(posedge clk) begin
        if (!rst_n) pend.delete();
        else if (ic.icache_req_valid_o && ic.icache_req_ready_i)
            pend.push_back('{due: cyc + lat, addr: ic.icache_addr_o});
        cyc++;
        #1;
        if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
            ic.icache_rvalid_i = 1'b1;
            ic.icache_rdata_i  = ic_data(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            ic.icache_rvalid_i = 1'b0;
            ic.icache_rdata_i  = 32'h0;
        end
    end

    task automatic test_reset();
        ready_in = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_out got %0b want 0", valid_out); end
        n_checks++; if (ic.icache_req_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_valid got %0b want 0", ic.icache_req_valid_o); end
        n_checks++; if (ic.icache_addr_o !== BASE) begin n_fail++; $display("[TB] FAIL reset_addr got %h want %h", ic.icache_addr_o, BASE); end
        n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc_out got %h want 0", pc_out); end
        n_checks++; if (instr_out !== 32'h13) begin n_fail++; $display("[TB] FAIL reset_instr_out got %h want 00000013", instr_out); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (ic.icache_req_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL first_req_valid got %0b want 1", ic.icache_req_valid_o); end
        n_checks++; if (ic.icache_addr_o !== BASE) begin n_fail++; $display("[TB] FAIL first_req_addr got %h want %h", ic.icache_addr_o, BASE); end
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 10 && !valid_out; k++) begin
            @(negedge clk); #1;
        end
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_start valid_out got %0b want 1", valid_out); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_valid[%0d] got %0b want 1", i, valid_out); end
            n_checks++; if (pc_out !== BASE + 32'(4 * i)) begin n_fail++; $display("[TB] FAIL stream_pc[%0d] got %h want %h", i, pc_out, BASE + 32'(4 * i)); end
            n_checks++; if (instr_out !== ic_data(BASE + 32'(4 * i))) begin n_fail++; $display("[TB] FAIL stream_instr[%0d] got %h want %h", i, instr_out, ic_data(BASE + 32'(4 * i))); end
            @(negedge clk); #1;
        end
        next_pc = BASE + 32'd32;
    endtask

    task automatic test_back_pressure();
        ready_in = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid got %0b want 1", valid_out); end
        n_checks++; if (dut.fifo_count !== 3'd4) begin n_fail++; $display("[TB] FAIL bp_count got %0d want 4", dut.fifo_count); end
        n_checks++; if (ic.icache_req_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_req_valid got %0b want 0", ic.icache_req_valid_o); end
        n_checks++; if (dut.inflight !== 2'd0) begin n_fail++; $display("[TB] FAIL bp_inflight got %0d want 0", dut.inflight); end
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (valid_out !== 1'b1 || pc_out !== next_pc + 32'(4 * i)) begin n_fail++; $display("[TB] FAIL bp_drain[%0d] got valid=%0b pc=%h want valid=1 pc=%h", i, valid_out, pc_out, next_pc + 32'(4 * i)); end
            if (i == 1) begin
                n_checks++; if (ic.icache_req_valid_o !== 1'b1 || ic.icache_addr_o !== next_pc + 32'd16) begin n_fail++; $display("[TB] FAIL bp_resume got valid=%0b addr=%h want valid=1 addr=%h", ic.icache_req_valid_o, ic.icache_addr_o, next_pc + 32'd16); end
            end
            if (i == 4) begin
                n_checks++; if (instr_out !== ic_data(next_pc + 32'd16)) begin n_fail++; $display("[TB] FAIL bp_resume_instr got %h want %h", instr_out, ic_data(next_pc + 32'd16)); end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_flush_inflight();
        bit found = 1'b0;
        lat = 3;
        flush_i = 1'b1; flush_pc_i = 32'h40;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        for (int k = 0; k < 30 && !found; k++) begin
            if (pend.size() == 2 && pend[0].addr == 32'h40 && pend[1].addr == 32'h44 && !ic.icache_rvalid_i) found = 1'b1;
            else begin @(negedge clk); #1; end
        end
        n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL fl2_setup got pending=%0d want 0x40 and 0x44 outstanding", pend.size()); end
        flush_i = 1'b1; flush_pc_i = 32'h2000;
        #1;
        n_checks++; if (ic.icache_req_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL fl2_req_during_flush got %0b want 0", ic.icache_req_valid_o); end
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL fl2_cleared got valid=%0b want 0", valid_out); end
        n_checks++; if (dut.drop !== 2'd2) begin n_fail++; $display("[TB] FAIL fl2_drop got %0d want 2", dut.drop); end
        for (int k = 0; k < 20 && !valid_out; k++) begin
            @(negedge clk); #1;
        end
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("[TB] FAIL fl2_first_valid got %0b want 1", valid_out); end
        n_checks++; if (pc_out !== 32'h2000) begin n_fail++; $display("[TB] FAIL fl2_first_pc got %h want 00002000", pc_out); end
        n_checks++; if (instr_out !== 32'hA5A5_2000) begin n_fail++; $display("[TB] FAIL fl2_first_instr got %h want a5a52000", instr_out); end
    endtask

    task automatic test_flush_coincident();
        bit found = 1'b0;
        int exp_drop = 0;
        int got = 0;
        ready_in = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (ic.icache_rvalid_i && valid_out && pend.size() >= 1) found = 1'b1;
            else begin @(negedge clk); #1; end
        end
        n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL flc_setup got no response+head+outstanding cycle want one"); end
        exp_drop = pend.size();
        ready_in = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h3000;
        #1;
        n_checks++; if (ic.icache_req_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL flc_req_during_flush got %0b want 0", ic.icache_req_valid_o); end
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL flc_cleared got valid=%0b want 0", valid_out); end
        n_checks++; if (dut.drop !== 2'(exp_drop)) begin n_fail++; $display("[TB] FAIL flc_drop got %0d want %0d", dut.drop, exp_drop); end
        for (int k = 0; k < 40 && got < 4; k++) begin
            if (valid_out) begin
                n_checks++; if (pc_out !== 32'h3000 + 32'(4 * got)) begin n_fail++; $display("[TB] FAIL flc_pc[%0d] got %h want %h", got, pc_out, 32'h3000 + 32'(4 * got)); end
                if (got == 0) begin
                    n_checks++; if (instr_out !== 32'hA5A5_3000) begin n_fail++; $display("[TB] FAIL flc_instr got %h want a5a53000", instr_out); end
                end
                got++;
            end
            @(negedge clk); #1;
        end
        n_checks++; if (got != 4) begin n_fail++; $display("[TB] FAIL flc_count got %0d entries want 4", got); end
    endtask

    task automatic test_async_reset();
        lat = 1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_valid_out got %0b want 0", valid_out); end
        n_checks++; if (ic.icache_req_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_req_valid got %0b want 0", ic.icache_req_valid_o); end
        n_checks++; if (ic.icache_addr_o !== BASE) begin n_fail++; $display("[TB] FAIL ar_addr got %h want %h", ic.icache_addr_o, BASE); end
        n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("[TB] FAIL ar_pc_out got %h want 0", pc_out); end
        n_checks++; if (instr_out !== 32'h13) begin n_fail++; $display("[TB] FAIL ar_instr_out got %h want 00000013", instr_out); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (ic.icache_req_valid_o !== 1'b1 || ic.icache_addr_o !== BASE) begin n_fail++; $display("[TB] FAIL ar_restart_req got valid=%0b addr=%h want valid=1 addr=%h", ic.icache_req_valid_o, ic.icache_addr_o, BASE); end
        for (int k = 0; k < 10 && !valid_out; k++) begin
            @(negedge clk); #1;
        end
        n_checks++; if (valid_out !== 1'b1 || pc_out !== BASE) begin n_fail++; $display("[TB] FAIL ar_first_out got valid=%0b pc=%h want valid=1 pc=%h", valid_out, pc_out, BASE); end
        n_checks++; if (instr_out !== 32'hA5A5_0100) begin n_fail++; $display("[TB] FAIL ar_first_instr got %h want a5a50100", instr_out); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        int got = 0;
        exp_pc[0] = 32'hFFFF_FFFC;
        exp_pc[1] = 32'h0000_0000;
        exp_pc[2] = 32'h0000_0004;
        flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFC;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        for (int k = 0; k < 20 && got < 3; k++) begin
            if (valid_out) begin
                n_checks++; if (pc_out !== exp_pc[got]) begin n_fail++; $display("[TB] FAIL wrap_pc[%0d] got %h want %h", got, pc_out, exp_pc[got]); end
                if (got == 1) begin
                    n_checks++; if (instr_out !== 32'hA5A5_0000) begin n_fail++; $display("[TB] FAIL wrap_instr got %h want a5a50000", instr_out); end
                end
                got++;
            end
            @(negedge clk); #1;
        end
        n_checks++; if (got != 3) begin n_fail++; $display("[TB] FAIL wrap_count got %0d entries want 3", got); end
    endtask

    initial begin
        ic.icache_req_ready_i = 1'b1;
        ic.icache_rvalid_i    = 1'b0;
        ic.icache_rdata_i     = 32'h0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_inflight();
        test_flush_coincident();
        test_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised successor to the single-entry fetch stage. It keeps up to `MAX_OUTSTANDING` icache requests in flight and buffers returned instructions in a `DEPTH`-entry prefetch FIFO, so decode sees back-to-back instructions with no per-instruction round-trip bubble. On a flush it redirects the PC, discards the buffered instructions, and silently drops responses for requests already in flight. It sits between the icache and decode.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥ 2.
- `MAX_OUTSTANDING`, 2: maximum icache requests in flight; ≥ 1.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1: clock. Single clock domain.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `flush_i`  in  1: redirect request; takes priority over every other event.
- `flush_pc_i`  in  32: redirect target.
- `ready_in`  in  1: decode accepts the head instruction.
- `valid_out`  out  1: FIFO head is valid.
- `pc_out`  out  32: PC of the FIFO head.
- `instr_out`  out  32: instruction of the FIFO head.
- `icache_req_valid_o`  out  1: request valid.
- `icache_req_ready_i`  in  1: icache accepts the request.
- `icache_addr_o`  out  32: request address.
- `icache_rvalid_i`  in  1: response valid. Responses return in order, at least 1 cycle after acceptance, and cannot be back-pressured.
- `icache_rdata_i`  in  32: response instruction.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `inflight`: accepted requests not yet answered; width `$clog2(MAX_OUTSTANDING+1)`.
  - `drop`: in-flight responses still to be discarded; same width as `inflight`.
  - FIFO of {pc, instr}; `count` width `$clog2(DEPTH+1)`.
  - Per-request PC queue of `MAX_OUTSTANDING` entries, so each response is paired with its address.
- Issue:
  - `icache_req_valid_o = !flush_i && inflight < MAX_OUTSTANDING && (inflight - drop) + count < DEPTH`.
  - All terms use current-cycle registered values; a dequeue in the same cycle does not count as free space.
- Request handshake (valid & ready): push `fetch_pc` into the PC queue, `fetch_pc += 4` (32-bit wrap), `inflight++`.
- Response (`icache_rvalid_i`):
  - Always pop the PC queue and decrement `inflight`.
  - If `drop > 0`: decrement `drop`; discard the data.
  - Else: enqueue {popped pc, `icache_rdata_i`}. The credit rule guarantees space.
- Dequeue: `valid_out & ready_in` pops the FIFO head.
- Flush cycle:
  - Clear the FIFO; `fetch_pc <= flush_pc_i`.
  - `drop <= inflight - icache_rvalid_i`.
  - A response arriving in this same cycle is discarded; it still decrements `inflight` and pops the PC queue.
  - No request is issued and any dequeue is ignored.
- When the FIFO is empty: `valid_out = 0`, `pc_out = 0`, `instr_out = 32'h0000_0013` (NOP).
- A response with `inflight == 0` is a protocol error: ignored and flagged by a simulation assertion.
- Reset (async, any time, including mid-burst):
  - `fetch_pc = RESET_PC`; `inflight`, `drop` and `count` = 0; FIFO and PC queue emptied.
  - Outputs: `valid_out = 0`, `icache_req_valid_o = 0`, `icache_addr_o = RESET_PC`, `pc_out = 0`, `instr_out = 32'h13`.
  - Responses still owed from before reset are the icache's responsibility; the icache is reset together with this block.

## Timing
- The first request is offered in the first cycle after `rst_n` deasserts (synchronised release), at address `RESET_PC`.
- A request accepted in cycle N with its response in cycle N+k gives `valid_out` in cycle N+k+1. The FIFO is registered; there is no response-to-output bypass.
- Steady state with a 1-cycle icache and `MAX_OUTSTANDING ≥ 2`: one instruction per cycle.
- Simultaneous enqueue and dequeue on a full FIFO are both performed; `count` is unchanged.
- After a flush in cycle F, the first request to `flush_pc_i` is offered in cycle F+1. It may be accepted while `drop > 0`; its response is kept because responses return in order.
- `icache_addr_o = fetch_pc` combinationally. `valid_out`, `pc_out` and `instr_out` come directly from registers or the FIFO head.

## Structure
- `fetch_pkg` holds:
  - `NOP_INSTR` = 32'h0000_0013;
  - the `fetch_entry_t` struct {pc[31:0], instr[31:0]};
  - a shared `clog2`-based counter-width helper.
- One sub-module, `fetch_fifo`: a synchronous circular-buffer FIFO parametrised by depth and entry type, with synchronous `clear`, async reset, and `count`/`full`/`empty` outputs. It is instantiated for the prefetch FIFO (`DEPTH`) and for the PC queue (`MAX_OUTSTANDING`).
- Total around 250 lines of RTL.

## Test plan
- Streaming: reset, `RESET_PC` = 0x100, icache always ready with 1-cycle latency, `ready_in = 1` → after warm-up, one instruction per cycle with PCs 0x100, 0x104, 0x108, …; `valid_out` never drops.
- Back-pressure: `ready_in = 0` for 20 cycles, DEPTH = 4 → exactly 4 entries buffered, `icache_req_valid_o` low with `inflight = 0`; releasing `ready_in` drains 4 entries in order, then fetch resumes at base + 16.
- Flush with 2 in flight: latency 3, flush to 0x2000 while requests 0x40 and 0x44 are outstanding → both responses discarded; first `valid_out` carries `pc_out = 0x2000` and the data returned for 0x2000.
- Flush coincident with a response and a dequeue: response is discarded, dequeue is ignored, `drop = inflight - 1`; no stale PC ever appears at the output.
- Async reset mid-burst: drop `rst_n` between clock edges → outputs reach their reset values immediately; after release, fetch restarts at `RESET_PC`.
- Wrap-around: flush to 0xFFFF_FFFC → PCs 0xFFFF_FFFC, then 0x0000_0000.
